id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection, bubble insertion and branch flush.
- Sits between decode and execute.
- Directly feeds the forwarding unit: id_ex_RegisterRs1/Rs2 for comparison against EX/MEM and MEM/WB destinations.
- Feeds the EX operand muxes and ALU control, and drives the stall enables for PC and IF/ID.

Parameters:
- XLEN, 32, datapath width (PC, operands, immediate).
- CTRL_W, 8, control bundle width. Bit layout: 0 RegWrite, 1 MemRead, 2 MemWrite, 3 MemtoReg, 4 ALUSrc, 5 Branch, 7:6 ALUOp.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID holds a real instruction.
- id_pc  input  XLEN  PC of the ID instruction.
- id_rs1_data  input  XLEN  register-file read port 1.
- id_rs2_data  input  XLEN  register-file read port 2.
- id_imm  input  XLEN  sign-extended immediate.
- id_rs1  input  5  source register 1 index.
- id_rs2  input  5  source register 2 index.
- id_rd  input  5  destination register index.
- id_uses_rs1  input  1  instruction reads rs1.
- id_uses_rs2  input  1  instruction reads rs2.
- id_ctrl  input  CTRL_W  decoded control bundle.
- id_funct  input  4  {funct7[5], funct3}.
- ex_flush  input  1  branch/jump taken in EX; kill the ID instruction.
- hold  input  1  global back-pressure (memory not ready); freeze the register.
- id_ex_valid  output  1  EX holds a real instruction.
- id_ex_pc  output  XLEN  registered PC.
- id_ex_rs1_data  output  XLEN  registered operand 1.
- id_ex_rs2_data  output  XLEN  registered operand 2.
- id_ex_imm  output  XLEN  registered immediate.
- id_ex_RegisterRs1  output  5  registered rs1 index, to forwarding unit.
- id_ex_RegisterRs2  output  5  registered rs2 index, to forwarding unit.
- id_ex_RegisterRd  output  5  registered rd index.
- id_ex_ctrl  output  CTRL_W  registered control bundle.
- id_ex_funct  output  4  registered funct bits.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID register update enable.

Behaviour:
- Reset (rst_n low, asynchronous): all registered outputs 0, so id_ex_valid=0 and id_ex_ctrl=0 (bubble). pc_write and if_id_write are combinational and follow the rules below using the reset-state register values.
- load_use (combinational) = id_ex_valid & id_ex_ctrl[1] & (id_ex_RegisterRd!=0) & id_valid & ((id_uses_rs1 & id_rs1==id_ex_RegisterRd) | (id_uses_rs2 & id_rs2==id_ex_RegisterRd)).
- pc_write = if_id_write = ~hold & ~(load_use & ~ex_flush).
- Next-state priority per clock edge, highest first:
  1. hold=1: every register keeps its value, including during a flush or load_use. The flush must be re-presented by EX while hold is high.
  2. ex_flush=1: load bubble (valid=0, ctrl=0, funct=0, all indices and data 0). load_use is ignored.
  3. load_use=1: load bubble. The ID instruction stays in IF/ID via if_id_write=0 and is re-evaluated next cycle.
  4. Otherwise: capture all id_* inputs. valid=id_valid. If id_valid=0, ctrl is forced to 0.
- Latency: exactly one cycle from ID inputs to id_ex_* outputs.
- A load-use stall lasts exactly one cycle: after the bubble, id_ex_valid=0, so load_use drops.
- Back-to-back loads with a dependent third instruction each stall once.
- rd=x0 never stalls. A store reading a loaded register via rs2 stalls (forwarding from MEM/WB resolves it afterwards).
- A bubble has ctrl[0]=0 (RegWrite=0), so it never triggers forwarding downstream.
- No combinational path from id_* data inputs to id_ex_* outputs.

Optional Feature:
- Macro ID_EX_STALL_CNT_EN.
- When defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on each edge where hold=0 & load_use=1 & ex_flush=0.
  - flush_cnt increments on each edge where hold=0 & ex_flush=1.
  - Both counters wrap at 2^32-1 to 0 and reset to 0.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-stream: apply valid instruction, pull rst_n low between edges -> id_ex_valid=0 and id_ex_ctrl=0 immediately, before the next edge; pc_write=1.
- Load-use: EX holds lw x5 (ctrl[1]=1, rd=5), ID holds add x6,x5,x7 with uses_rs1 -> pc_write=if_id_write=0 for one cycle; next edge id_ex_valid=0; following edge id_ex_RegisterRs1=5 and valid=1.
- x0 and unused source: lw x0 followed by user of x0 -> no stall. lw x5 followed by lui x5 (uses_rs1=uses_rs2=0) -> no stall.
- Flush vs stall: load_use=1 and ex_flush=1 together -> pc_write=1, bubble captured. With ID_EX_STALL_CNT_EN: flush_cnt +1, stall_cnt unchanged.
- Hold: hold=1 for 3 cycles with ID changing -> id_ex_* unchanged and pc_write=0 throughout; on release, the current ID is captured.
- Passthrough: id_pc=0x100, id_imm=0xFFFFFFF0, ctrl=0x31 -> identical values on id_ex_* one cycle later.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, bubble insertion and flush
//
// Purpose : registers the decoded instruction between ID and EX, detects a
//           load-use hazard against the instruction currently in EX, and
//           drives the PC / IF-ID write enables.
// Ports   : clk, rst_n (async active-low)
//           id_*       decoded instruction from ID
//           ex_flush   branch/jump taken in EX, kill the ID instruction
//           hold       global back-pressure, freeze the register
//           id_ex_*    registered instruction to EX and forwarding unit
//           pc_write, if_id_write  stall enables for PC and IF/ID
// Option  : ID_EX_STALL_CNT_EN adds stall_cnt / flush_cnt event counters.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [3:0]        id_funct,
    input  logic              ex_flush,
    input  logic              hold,
    output logic              id_ex_valid,
    output logic [XLEN-1:0]   id_ex_pc,
    output logic [XLEN-1:0]   id_ex_rs1_data,
    output logic [XLEN-1:0]   id_ex_rs2_data,
    output logic [XLEN-1:0]   id_ex_imm,
    output logic [4:0]        id_ex_RegisterRs1,
    output logic [4:0]        id_ex_RegisterRs2,
    output logic [4:0]        id_ex_RegisterRd,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic [3:0]        id_ex_funct,
    output logic              pc_write,
    output logic              if_id_write
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam int CTRL_MEMREAD = 1;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [4:0]        rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [3:0]        funct_q, funct_d;

    logic load_use;
    logic rs1_hit;
    logic rs2_hit;

    // Hazard only when EX holds a real load to a non-zero register that the
    // ID instruction actually reads.
    always_comb begin
        rs1_hit  = id_uses_rs1 && (id_rs1 == rd_q);
        rs2_hit  = id_uses_rs2 && (id_rs2 == rd_q);
        load_use = valid_q && ctrl_q[CTRL_MEMREAD] && (rd_q != 5'd0) &&
                   id_valid && (rs1_hit || rs2_hit);
    end

    // A flush discards the ID instruction anyway, so it overrides the stall.
    always_comb begin
        pc_write    = !hold && !(load_use && !ex_flush);
        if_id_write = pc_write;
    end

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        ctrl_d     = ctrl_q;
        funct_d    = funct_q;
        if (hold) begin
            // keep everything
        end else if (ex_flush || load_use) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            ctrl_d     = '0;
            funct_d    = '0;
        end else begin
            valid_d    = id_valid;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            // an invalid slot must never assert RegWrite/MemWrite downstream
            ctrl_d     = id_valid ? id_ctrl : '0;
            funct_d    = id_funct;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            ctrl_q     <= '0;
            funct_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
            funct_q    <= funct_d;
        end
    end

    assign id_ex_valid       = valid_q;
    assign id_ex_pc          = pc_q;
    assign id_ex_rs1_data    = rs1_data_q;
    assign id_ex_rs2_data    = rs2_data_q;
    assign id_ex_imm         = imm_q;
    assign id_ex_RegisterRs1 = rs1_q;
    assign id_ex_RegisterRs2 = rs2_q;
    assign id_ex_RegisterRd  = rd_q;
    assign id_ex_ctrl        = ctrl_q;
    assign id_ex_funct       = funct_q;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!hold && ex_flush) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else if (!hold && load_use) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [7:0]  id_ctrl;
    logic [3:0]  id_funct;
    logic        ex_flush;
    logic        hold;
    logic        id_ex_valid;
    logic [31:0] id_ex_pc;
    logic [31:0] id_ex_rs1_data;
    logic [31:0] id_ex_rs2_data;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_RegisterRs1;
    logic [4:0]  id_ex_RegisterRs2;
    logic [4:0]  id_ex_RegisterRd;
    logic [7:0]  id_ex_ctrl;
    logic [3:0]  id_ex_funct;
    logic        pc_write;
    logic        if_id_write;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    id_ex_stage #(.XLEN(32), .CTRL_W(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_valid          (id_valid),
        .id_pc             (id_pc),
        .id_rs1_data       (id_rs1_data),
        .id_rs2_data       (id_rs2_data),
        .id_imm            (id_imm),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .id_rd             (id_rd),
        .id_uses_rs1       (id_uses_rs1),
        .id_uses_rs2       (id_uses_rs2),
        .id_ctrl           (id_ctrl),
        .id_funct          (id_funct),
        .ex_flush          (ex_flush),
        .hold              (hold),
        .id_ex_valid       (id_ex_valid),
        .id_ex_pc          (id_ex_pc),
        .id_ex_rs1_data    (id_ex_rs1_data),
        .id_ex_rs2_data    (id_ex_rs2_data),
        .id_ex_imm         (id_ex_imm),
        .id_ex_RegisterRs1 (id_ex_RegisterRs1),
        .id_ex_RegisterRs2 (id_ex_RegisterRs2),
        .id_ex_RegisterRd  (id_ex_RegisterRd),
        .id_ex_ctrl        (id_ex_ctrl),
        .id_ex_funct       (id_ex_funct),
        .pc_write          (pc_write),
        .if_id_write       (if_id_write)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one rising edge, return on the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic v, input logic [31:0] pc,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic u1, input logic u2, input logic [7:0] ctrl);
        id_valid    = v;
        id_pc       = pc;
        id_rs1_data = pc + 32'd1;
        id_rs2_data = pc + 32'd2;
        id_imm      = pc + 32'd3;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        id_ctrl     = ctrl;
        id_funct    = 4'h0;
    endtask

    initial begin
        rst_n    = 1'b0;
        ex_flush = 1'b0;
        hold     = 1'b0;
        set_instr(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        check("reset_valid", id_ex_valid, 0);
        check("reset_ctrl", id_ex_ctrl, 0);
        check("reset_pc_write", pc_write, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // passthrough
        set_instr(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 8'h31);
        id_imm      = 32'hFFFF_FFF0;
        id_rs1_data = 32'hDEAD_BEEF;
        id_funct    = 4'hA;
        #1;
        check("pass_no_comb_path", id_ex_pc, 0);
        tick();
        check("pass_valid", id_ex_valid, 1);
        check("pass_pc", id_ex_pc, 32'h100);
        check("pass_imm", id_ex_imm, 32'hFFFF_FFF0);
        check("pass_ctrl", id_ex_ctrl, 8'h31);
        check("pass_rs1_data", id_ex_rs1_data, 32'hDEAD_BEEF);
        check("pass_rs2_data", id_ex_rs2_data, 32'h102);
        check("pass_rd", id_ex_RegisterRd, 3);
        check("pass_funct", id_ex_funct, 4'hA);

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("areset_valid", id_ex_valid, 0);
        check("areset_ctrl", id_ex_ctrl, 0);
        check("areset_pc_write", pc_write, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // invalid slot: ctrl forced to 0
        set_instr(1'b0, 32'h140, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 8'hFF);
        tick();
        check("inval_valid", id_ex_valid, 0);
        check("inval_ctrl", id_ex_ctrl, 0);
        check("inval_pc", id_ex_pc, 32'h140);

        // load-use: lw x5 then add x6,x5,x7
        set_instr(1'b1, 32'h200, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 8'h0B);
        tick();
        set_instr(1'b1, 32'h204, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 8'h01);
        #1;
        check("lu_pc_write", pc_write, 0);
        check("lu_if_id_write", if_id_write, 0);
        tick();
        check("lu_bubble_valid", id_ex_valid, 0);
        check("lu_bubble_ctrl", id_ex_ctrl, 0);
        check("lu_bubble_rd", id_ex_RegisterRd, 0);
        check("lu_release_pc_write", pc_write, 1);
        tick();
        check("lu_after_valid", id_ex_valid, 1);
        check("lu_after_rs1", id_ex_RegisterRs1, 5);
        check("lu_after_pc", id_ex_pc, 32'h204);

        // lw x0 followed by reader of x0: no stall
        set_instr(1'b1, 32'h300, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 8'h0B);
        tick();
        set_instr(1'b1, 32'h304, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 8'h01);
        #1;
        check("x0_pc_write", pc_write, 1);
        tick();
        check("x0_captured_pc", id_ex_pc, 32'h304);

        // lw x5 followed by lui x5 (no sources): no stall
        set_instr(1'b1, 32'h400, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 8'h0B);
        tick();
        set_instr(1'b1, 32'h404, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 8'h11);
        #1;
        check("lui_pc_write", pc_write, 1);
        tick();
        check("lui_captured_pc", id_ex_pc, 32'h404);

        // back-to-back loads: lw x5; lw x6,0(x5); add x7,x6,x0
        set_instr(1'b1, 32'h500, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 8'h0B);
        tick();
        set_instr(1'b1, 32'h504, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 8'h0B);
        #1;
        check("b2b_stall1", pc_write, 0);
        tick();
        check("b2b_bubble1", id_ex_valid, 0);
        tick();
        check("b2b_second_load_pc", id_ex_pc, 32'h504);
        set_instr(1'b1, 32'h508, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0, 8'h01);
        #1;
        check("b2b_stall2", pc_write, 0);
        tick();
        check("b2b_bubble2", id_ex_valid, 0);
        check("b2b_no_third_stall", pc_write, 1);
        tick();
        check("b2b_third_pc", id_ex_pc, 32'h508);

        // store reads loaded reg via rs2: stall; with flush the stall is overridden
        set_instr(1'b1, 32'h600, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 8'h0B);
        tick();
        set_instr(1'b1, 32'h604, 5'd2, 5'd5, 5'd0, 1'b1, 1'b1, 8'h04);
        #1;
        check("sw_rs2_stall", pc_write, 0);
`ifdef ID_EX_STALL_CNT_EN
        check("cnt_stall_before_flush", stall_cnt, 3);
        check("cnt_flush_before", flush_cnt, 0);
`endif
        ex_flush = 1'b1;
        #1;
        check("flush_pc_write", pc_write, 1);
        tick();
        ex_flush = 1'b0;
        check("flush_valid", id_ex_valid, 0);
        check("flush_ctrl", id_ex_ctrl, 0);
        check("flush_pc", id_ex_pc, 0);
`ifdef ID_EX_STALL_CNT_EN
        check("cnt_stall_after_flush", stall_cnt, 3);
        check("cnt_flush_after", flush_cnt, 1);
`endif

        // hold for three cycles while ID changes (and a flush arrives)
        set_instr(1'b1, 32'h700, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 8'h11);
        tick();
        check("hold_pre_pc", id_ex_pc, 32'h700);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 32'h800 + 32'(i * 4), 5'd3, 5'd4, 5'd10, 1'b1, 1'b1, 8'h21);
            ex_flush = (i == 1);
            #1;
            check("hold_pc_write", pc_write, 0);
            tick();
            check("hold_pc_kept", id_ex_pc, 32'h700);
            check("hold_valid_kept", id_ex_valid, 1);
        end
        hold     = 1'b0;
        ex_flush = 1'b0;
        #1;
        check("hold_release_pc_write", pc_write, 1);
        tick();
        check("hold_release_pc", id_ex_pc, 32'h808);
        check("hold_release_ctrl", id_ex_ctrl, 8'h21);
`ifdef ID_EX_STALL_CNT_EN
        check("cnt_flush_held", flush_cnt, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
